// File: rtl/hdmi_video_timing_ctrl_pkg.sv
// Shared constants and types for the HDMI raster scheduler.
// Defaults describe 640x480@60 on a 25.175 MHz pixel clock.
package hdmi_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } vt_state_e;

    // Shown on screen whenever an active pixel finds the source empty.
    localparam logic [23:0] UNDERFLOW_RGB = 24'hFF00FF;

endpackage

// File: rtl/hdmi_video_timing_ctrl_if.sv
// Upstream pixel stream: valid/ready handshake carrying one {R,G,B} pixel per beat.
interface hdmi_video_timing_ctrl_if;

    logic        s_valid;
    logic        s_ready;
    logic [23:0] s_data;

    modport master (output s_valid, output s_data, input  s_ready);
    modport slave  (input  s_valid, input  s_data, output s_ready);

endinterface

// File: rtl/hdmi_video_timing_ctrl_raster_counter.sv
// Horizontal/vertical raster position with wrap; holds while not advancing.
module hdmi_raster_counter
    import hdmi_timing_pkg::*;
#(
    parameter int H_TOTAL = DEF_H_TOTAL,
    parameter int V_TOTAL = DEF_V_TOTAL
) (
    input  logic        clk_low,
    input  logic        reset,
    input  logic        advance,
    output logic [11:0] h,
    output logic [10:0] v,
    output logic        eof
);

    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);

    assign eof = (h == H_LAST) && (v == V_LAST);

    always_ff @(posedge clk_low or posedge reset) begin
        if (reset) begin
            h <= '0;
            v <= '0;
        end else if (advance) begin
            if (h == H_LAST) begin
                h <= '0;
                v <= (v == V_LAST) ? '0 : v + 11'd1;
            end else begin
                h <= h + 12'd1;
            end
        end
    end

endmodule

// File: rtl/hdmi_video_timing_ctrl.sv
// Raster scheduler ahead of the HDMI transceiver: sync/DE generation, pixel pull, underflow flag.
//   state   | meaning
//   ST_IDLE | raster parked at (0,0), outputs blank, no pixels pulled
//   ST_RUN  | raster advancing, enable held high
//   ST_STOP | enable dropped; finishing the current frame, then back to IDLE
module hdmi_video_timing_ctrl
    import hdmi_timing_pkg::*;
#(
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic                      clk_low,
    input  logic                      reset,
    input  logic                      enable,
    hdmi_video_timing_ctrl_if.slave   pix,
    output logic [7:0]                red,
    output logic [7:0]                green,
    output logic [7:0]                blue,
    output logic                      hsync,
    output logic                      vsync,
    output logic                      de,
    output logic                      frame_start,
    output logic [11:0]               h_count,
    output logic [10:0]               v_count,
    output logic                      underflow,
    input  logic                      clr_underflow
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_ACT_END = 12'(H_ACTIVE);
    localparam logic [11:0] HS_START  = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END    = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT_END = 11'(V_ACTIVE);
    localparam logic [10:0] VS_START  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);

    vt_state_e   state;
    logic [11:0] h;
    logic [10:0] v;
    logic        eof;
    logic        running;
    logic        active;
    logic        pixel_slot;
    logic        hs_on;
    logic        vs_on;

    hdmi_raster_counter #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL)
    ) u_raster (
        .clk_low (clk_low),
        .reset   (reset),
        .advance (running),
        .h       (h),
        .v       (v),
        .eof     (eof)
    );

    assign running    = (state != ST_IDLE);
    assign active     = (h < H_ACT_END) && (v < V_ACT_END);
    assign pixel_slot = running && active;
    assign hs_on      = (h >= HS_START) && (h < HS_END);
    assign vs_on      = (v >= VS_START) && (v < VS_END);

    // Ready depends only on registered state and position, never on s_valid.
    assign pix.s_ready = pixel_slot;

    always_ff @(posedge clk_low or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            de          <= 1'b0;
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            frame_start <= 1'b0;
            h_count     <= '0;
            v_count     <= '0;
            underflow   <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: if (enable) state <= ST_RUN;
                ST_RUN:  if (!enable) state <= ST_STOP;
                ST_STOP: begin
                    if (enable)   state <= ST_RUN;
                    else if (eof) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            // The raster never stalls: an empty source gets the underflow colour instead.
            if (pixel_slot) begin
                de                  <= 1'b1;
                {red, green, blue}  <= pix.s_valid ? pix.s_data : UNDERFLOW_RGB;
            end else begin
                de                  <= 1'b0;
                {red, green, blue}  <= '0;
            end

            hsync       <= hs_on ? HSYNC_POL : ~HSYNC_POL;
            vsync       <= vs_on ? VSYNC_POL : ~VSYNC_POL;
            frame_start <= running && (h == '0) && (v == '0);
            h_count     <= h;
            v_count     <= v;

            if (pixel_slot && !pix.s_valid) underflow <= 1'b1;
            else if (clr_underflow)         underflow <= 1'b0;
        end
    end

endmodule

// File: doc/hdmi_video_timing_ctrl.md
# hdmi_video_timing_ctrl

Raster scheduler in front of the HDMI transceiver. It generates the horizontal and vertical timing (hsync, vsync, data enable) on the pixel clock. It pulls pixels from an upstream source over a valid/ready handshake only during active video, and drives the transceiver's red/green/blue inputs. It also starts and stops cleanly on frame boundaries and flags source underflow.

## Interface
Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, active lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HSYNC_POL, 0, asserted level of hsync
- VSYNC_POL, 0, asserted level of vsync

Ports:
- clk_low  in  1  pixel clock; the block's only clock
- reset  in  1  asynchronous, active-high
- enable  in  1  run request, level-sensitive
- s_valid  in  1  upstream pixel valid
- s_ready  out  1  pixel consumed this cycle when s_valid && s_ready
- s_data  in  24  pixel {R[23:16], G[15:8], B[7:0]}
- red, green, blue  out  8 each  to transceiver
- hsync, vsync, de  out  1 each  raster timing
- frame_start  out  1  one-cycle pulse with pixel (0,0) on the outputs
- h_count  out  12  horizontal position of the current outputs
- v_count  out  11  vertical position of the current outputs
- underflow  out  1  sticky: active pixel had no valid data
- clr_underflow  in  1  clears underflow

## Operation
- Derived values: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 at defaults); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 at defaults).
- Internal counters h, v:
  - h counts 0..H_TOTAL-1, then wraps to 0 and increments v.
  - v wraps to 0 after V_TOTAL-1.
- active = (h < H_ACTIVE) && (v < V_ACTIVE).
- hsync is asserted (HSYNC_POL) for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). At defaults: 656..751.
- vsync is asserted (VSYNC_POL) for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC). At defaults: 490..491.
- State machine IDLE / RUN / STOP:
  - IDLE: h = v = 0, held. enable=1 moves to RUN; the first RUN cycle is h=0, v=0.
  - RUN: counters advance every cycle. enable=0 moves to STOP.
  - STOP: counters keep advancing. At h=H_TOTAL-1, v=V_TOTAL-1, go to IDLE. If enable=1 earlier, return to RUN with no raster break.
- Pixel path:
  - s_ready = (state != IDLE) && active. s_ready is never asserted in blanking.
  - active && s_valid: output s_data, de=1.
  - active && !s_valid: output magenta 0xFF00FF, de=1, set underflow. No source stall: the raster never pauses.
  - Blanking or IDLE: rgb=0, de=0.
- underflow: if set and clr_underflow occur in the same cycle, set wins.
- Frames are never truncated. Only reset aborts a frame.

## Timing
- Registered outputs. red/green/blue, hsync, vsync, de, frame_start, h_count and v_count reflect the counter values of the previous cycle: 1-cycle latency, all mutually aligned.
- s_ready is combinational from state and counter registers only, never from s_valid. Data accepted in cycle n appears on the outputs in cycle n+1.
- frame_start=1 exactly in the output cycle where h_count=0, v_count=0 and the state was RUN or STOP.
- Reset values, applied immediately (async):
  - state IDLE, h=v=0
  - rgb=0, de=0, frame_start=0, underflow=0, s_ready=0
  - hsync=~HSYNC_POL, vsync=~VSYNC_POL
  - h_count=0, v_count=0
- Reset mid-frame: no partial-frame recovery. After release, the block restarts from IDLE.

## Structure
- Shared package hdmi_timing_pkg holds:
  - the default 640x480@60 constants, H_TOTAL and V_TOTAL
  - the state encoding (IDLE, RUN, STOP)
  - the underflow colour 24'hFF00FF
- One sub-module, hdmi_raster_counter: h/v counters with wrap, hold when stopped, and end-of-frame flag.
- The top holds the FSM, pixel mux, output registers and underflow flag.

## Test plan
- Reset asserted mid-line at h=300, v=100 -> all outputs take reset values within the same cycle; after release, no activity until enable.
- enable=1, s_valid=1, s_data=24'h00FF00:
  - de high 640 cycles per line, green=8'hFF, red=blue=0
  - hsync low h_count 656..751; vsync low v_count 490..491
  - frame_start every 420000 cycles
- s_valid dropped for 3 cycles at v=5, h=100..102 -> outputs 0xFF00FF for those 3 pixels with de=1, underflow=1 and held. clr_underflow=1 -> 0 next cycle. Simultaneous new underflow and clear -> stays 1.
- s_valid held high through blanking -> s_ready=0 for h>=640 or v>=480; no beats consumed (upstream counter of accepted beats equals 307200 per frame).
- enable=0 at v=200 -> raster runs to v=524, h=799, then IDLE: de=0, s_ready=0, no further frame_start.
- enable deasserted at v=200 and reasserted at v=300 -> frame_start interval stays exactly 420000, no gap.
